intr_ack_sequencer: RTL and testbench
=====================================

// Module: intr_ack_sequencer
// PURPOSE
//  CPU-side consumer of the 8259 PIC's simple-acknowledge interface.
//  - Samples interrupt_to_cpu at instruction boundaries and drives the PIC's interrupt_acknowledge_simple pulse.
//  - Latches the vector from simpleirq and hands it to the CPU core over a valid/ready handshake.
//  - Arbitrates edge-triggered NMI (fixed vector 8'h02) above maskable INTR.
// PARAMETERS
//  ACK_CYCLES      5     clocks pic_ack is held high (1..15)
//  HOLDOFF_CYCLES  2     clocks after vector_taken before INTR is sampled again (0..15)
//  NMI_VECTOR      8'h02 vector delivered for NMI
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-high; clears all state
//  intr_in        in   1  from PIC interrupt_to_cpu
//  pic_vector     in   8  from PIC simpleirq
//  pic_ack        out  1  to PIC interrupt_acknowledge_simple
//  nmi            in   1  non-maskable request, rising-edge sensitive
//  cpu_if         in   1  CPU interrupt-enable flag (IF)
//  inst_boundary  in   1  CPU is between instructions; requests accepted only when 1
//  vector_out     out  8  vector presented to CPU
//  vector_valid   out  1  vector_out is valid
//  vector_is_nmi  out  1  qualifies vector_out as NMI
//  vector_taken   in   1  CPU accepts vector (ready)
//  spurious       out  1  1-cycle pulse: INTR dropped during ack, no vector delivered
//  busy           out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset (async): all outputs 0; state=IDLE; nmi_pending=0; counters=0; nmi edge register=0. Mid-sequence reset drops pic_ack in the same instant.
//  NMI edge detect: nmi_pending set on nmi 0->1 (registered previous value); cleared when an NMI vector is taken. Further edges while pending are absorbed.
//  States:
//   IDLE: on a cycle with inst_boundary=1:
//    - nmi_pending=1 -> PRESENT: vector_out=NMI_VECTOR, vector_is_nmi=1, next cycle.
//    - else intr_in=1 & cpu_if=1 -> ACK.
//    - NMI wins if both are true in the same cycle.
//   ACK: pic_ack=1 for exactly ACK_CYCLES clocks.
//    - intr_in is sampled on the final ACK clock.
//    - intr_in=1: latch pic_vector into vector_out, vector_is_nmi=0 -> PRESENT.
//    - intr_in=0: spurious=1 for one clock, no vector -> HOLDOFF.
//    - NMI arriving during ACK stays pending; the ack is never aborted.
//   PRESENT: vector_valid=1; vector_out and vector_is_nmi held stable.
//    - vector_taken=1 in this state: vector_valid=0 next clock -> HOLDOFF; if NMI, clear nmi_pending.
//    - vector_taken while not PRESENT is ignored.
//   HOLDOFF: count HOLDOFF_CYCLES clocks -> IDLE. With HOLDOFF_CYCLES=0, go directly to IDLE.
//  Latency: intr_in & cpu_if & inst_boundary at edge N -> pic_ack high N+1..N+ACK_CYCLES -> vector_valid high from N+ACK_CYCLES+1.
//  cpu_if and inst_boundary are checked only in IDLE; later changes do not cancel a sequence in progress.
//  busy=1 in every state except IDLE.
//  Counters are 4 bits and saturate at terminal count; no wrap.
// TESTING
//  1 PIC ICW1=13h, ICW2=08h, ICW4=01h, OCW1=00h, IRQ3 raised, cpu_if=1, inst_boundary=1
//    -> pic_ack high 5 clk; vector_valid with vector_out=8'h0B; vector_taken -> valid drops next clk; EOI 20h clears intr.
//  2 nmi rising while intr_in=1 in IDLE
//    -> vector_out=8'h02, vector_is_nmi=1, no pic_ack; after take + 2 clk holdoff, INTR ack begins.
//  3 intr_in=1 with cpu_if=0 for 50 clk
//    -> pic_ack stays 0, busy=0; raising cpu_if starts ack next boundary.
//  4 intr_in dropped before last ACK clock
//    -> spurious pulses 1 clk, vector_valid never asserts, return to IDLE after holdoff.
//  5 vector_taken held 0 for 20 clk in PRESENT
//    -> vector_valid and vector_out stable throughout.
//  6 reset asserted mid-ACK (cycle 3)
//    -> pic_ack, vector_valid, busy, nmi_pending all 0 without waiting for clk; clean sequence after release.

Source files
------------

// File: rtl/intr_ack_sequencer.sv
// rtl/intr_ack_sequencer.sv - CPU-side interrupt acknowledge sequencer for the 8259 simple-ack interface
//
// Purpose:
//   Samples the PIC interrupt request at instruction boundaries, drives the
//   PIC acknowledge pulse, latches the returned vector and offers it to the
//   CPU core over a valid/ready handshake. A rising edge on nmi takes priority
//   over maskable INTR and delivers NMI_VECTOR without touching the PIC.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   intr_in        in   PIC interrupt_to_cpu
//   pic_vector     in   PIC simpleirq vector
//   pic_ack        out  PIC interrupt_acknowledge_simple
//   nmi            in   non-maskable request, rising-edge sensitive
//   cpu_if         in   CPU interrupt-enable flag
//   inst_boundary  in   CPU is between instructions
//   vector_out     out  vector presented to CPU
//   vector_valid   out  vector_out is valid
//   vector_is_nmi  out  vector_out belongs to an NMI
//   vector_taken   in   CPU accepts the vector
//   spurious       out  one-clock pulse when INTR vanished during the ack
//   busy           out  sequencer not idle

module intr_ack_sequencer #(
   parameter int unsigned ACK_CYCLES     = 5,
   parameter int unsigned HOLDOFF_CYCLES = 2,
   parameter logic [7:0]  NMI_VECTOR     = 8'h02
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       intr_in,
   input  logic [7:0] pic_vector,
   output logic       pic_ack,
   input  logic       nmi,
   input  logic       cpu_if,
   input  logic       inst_boundary,
   output logic [7:0] vector_out,
   output logic       vector_valid,
   output logic       vector_is_nmi,
   input  logic       vector_taken,
   output logic       spurious,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_PRESENT,
      ST_HOLDOFF
   } state_t;

   localparam logic [3:0] ACK_LAST  = 4'(ACK_CYCLES);
   localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_CYCLES);

   state_t     state;
   logic [3:0] ack_cnt;
   logic [3:0] hold_cnt;
   logic       nmi_prev;
   logic       nmi_pending;
   logic       nmi_edge;
   logic       nmi_req;

   // An edge arriving on the same clock as an IDLE decision already counts,
   // so an NMI always beats an INTR that shows up in the same cycle.
   assign nmi_edge = nmi & ~nmi_prev;
   assign nmi_req  = nmi_pending | nmi_edge;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         ack_cnt       <= 4'd0;
         hold_cnt      <= 4'd0;
         nmi_prev      <= 1'b0;
         nmi_pending   <= 1'b0;
         pic_ack       <= 1'b0;
         vector_out    <= 8'h00;
         vector_valid  <= 1'b0;
         vector_is_nmi <= 1'b0;
         spurious      <= 1'b0;
      end else begin
         nmi_prev <= nmi;
         spurious <= 1'b0;
         if (nmi_edge)
            nmi_pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (inst_boundary) begin
                  if (nmi_req) begin
                     vector_out    <= NMI_VECTOR;
                     vector_is_nmi <= 1'b1;
                     vector_valid  <= 1'b1;
                     state         <= ST_PRESENT;
                  end else if (intr_in && cpu_if) begin
                     pic_ack <= 1'b1;
                     ack_cnt <= 4'd1;
                     state   <= ST_ACK;
                  end
               end
            end

            ST_ACK: begin
               // ack_cnt counts the clocks pic_ack has been high; the final
               // one is where the PIC's answer is judged.
               if (ack_cnt >= ACK_LAST) begin
                  pic_ack <= 1'b0;
                  ack_cnt <= 4'd0;
                  if (intr_in) begin
                     vector_out    <= pic_vector;
                     vector_is_nmi <= 1'b0;
                     vector_valid  <= 1'b1;
                     state         <= ST_PRESENT;
                  end else begin
                     spurious <= 1'b1;
                     hold_cnt <= 4'd0;
                     state    <= (HOLD_LAST == 4'd0) ? ST_IDLE : ST_HOLDOFF;
                  end
               end else if (ack_cnt != 4'hF) begin
                  ack_cnt <= ack_cnt + 4'd1;
               end
            end

            ST_PRESENT: begin
               if (vector_taken) begin
                  vector_valid <= 1'b0;
                  // Clearing after the edge-set above makes a coincident
                  // edge count as absorbed by the NMI being delivered.
                  if (vector_is_nmi)
                     nmi_pending <= 1'b0;
                  hold_cnt <= 4'd0;
                  state    <= (HOLD_LAST == 4'd0) ? ST_IDLE : ST_HOLDOFF;
               end
            end

            ST_HOLDOFF: begin
               if (({1'b0, hold_cnt} + 5'd1) >= {1'b0, HOLD_LAST}) begin
                  hold_cnt <= 4'd0;
                  state    <= ST_IDLE;
               end else if (hold_cnt != 4'hF) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// tb/tb_intr_ack_sequencer.sv - self-checking bench for intr_ack_sequencer
module tb_intr_ack_sequencer;

   localparam int ACK  = 5;
   localparam int HOLD = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       intr_in, nmi, cpu_if, inst_boundary, vector_taken;
   logic [7:0] pic_vector;
   logic       pic_ack, vector_valid, vector_is_nmi, spurious, busy;
   logic [7:0] vector_out;

   int n_checks = 0;
   int n_pass   = 0;

   intr_ack_sequencer #(.ACK_CYCLES(ACK), .HOLDOFF_CYCLES(HOLD), .NMI_VECTOR(8'h02)) dut (
      .clk(clk), .reset(reset), .intr_in(intr_in), .pic_vector(pic_vector),
      .pic_ack(pic_ack), .nmi(nmi), .cpu_if(cpu_if), .inst_boundary(inst_boundary),
      .vector_out(vector_out), .vector_valid(vector_valid), .vector_is_nmi(vector_is_nmi),
      .vector_taken(vector_taken), .spurious(spurious), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: phase of the interrupt transaction plus countdowns of
   // the clocks left in the ack window and in the holdoff window.
   int         m_phase;   // 0 idle, 1 acking PIC, 2 offering vector, 3 holdoff
   int         m_ack_left, m_hold_left;
   bit         m_pend, m_prev, m_spur, m_isnmi;
   logic [7:0] m_vec;

   function automatic void m_reset();
      m_phase = 0; m_ack_left = 0; m_hold_left = 0;
      m_pend = 0; m_prev = 0; m_spur = 0; m_isnmi = 0; m_vec = 8'h00;
   endfunction

   function automatic void m_enter_hold();
      m_hold_left = HOLD;
      m_phase = (HOLD == 0) ? 0 : 3;
   endfunction

   function automatic void m_step();
      bit edge_seen, want_nmi;
      edge_seen = nmi && !m_prev;
      m_prev    = nmi;
      want_nmi  = m_pend || edge_seen;
      if (edge_seen) m_pend = 1;
      m_spur = 0;
      case (m_phase)
         0: if (inst_boundary) begin
               if (want_nmi) begin m_phase = 2; m_vec = 8'h02; m_isnmi = 1; end
               else if (intr_in && cpu_if) begin m_phase = 1; m_ack_left = ACK; end
            end
         1: begin
               m_ack_left--;
               if (m_ack_left == 0) begin
                  if (intr_in) begin m_phase = 2; m_vec = pic_vector; m_isnmi = 0; end
                  else begin m_spur = 1; m_enter_hold(); end
               end
            end
         2: if (vector_taken) begin
               if (m_isnmi) m_pend = 0;
               m_enter_hold();
            end
         default: begin
               m_hold_left--;
               if (m_hold_left == 0) m_phase = 0;
            end
      endcase
   endfunction

   task automatic check_model();
      check("m_pic_ack", {7'd0, pic_ack}, {7'd0, m_phase == 1});
      check("m_valid",   {7'd0, vector_valid}, {7'd0, m_phase == 2});
      check("m_busy",    {7'd0, busy}, {7'd0, m_phase != 0});
      check("m_spur",    {7'd0, spurious}, {7'd0, m_spur});
      if (m_phase == 2) begin
         check("m_vec", vector_out, m_vec);
         check("m_isnmi", {7'd0, vector_is_nmi}, {7'd0, m_isnmi});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic set_in(input logic i, input logic [7:0] v, input logic n,
                         input logic f, input logic b, input logic t);
      intr_in = i; pic_vector = v; nmi = n; cpu_if = f; inst_boundary = b; vector_taken = t;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      set_in(0, 8'h00, 0, 0, 0, 0);
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      #4;
   endtask

   typedef struct {
      logic       intr; logic [7:0] vec; logic nmi_i, ifl, ib, taken;
      logic       e_ack, e_val, e_busy, e_spur, e_nmi; logic [7:0] e_vec;
   } row_t;

   row_t tbl[24];

   function automatic row_t mk(logic i, logic n, logic t, logic ea, logic ev,
                               logic eb, logic es, logic en, logic [7:0] evec);
      row_t r;
      r.intr = i; r.vec = 8'h0B; r.nmi_i = n; r.ifl = 1'b1; r.ib = 1'b1; r.taken = t;
      r.e_ack = ea; r.e_val = ev; r.e_busy = eb; r.e_spur = es; r.e_nmi = en; r.e_vec = evec;
      return r;
   endfunction

   initial begin
      // IRQ3 with ICW2=08h -> vector 0Bh; full ack, present, take, holdoff
      for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 1, 0, 1, 0, 0, 8'h00);
      tbl[5]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h0B);
      tbl[6]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h0B);
      tbl[7]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
      tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      // NMI rises together with a live INTR: NMI wins, INTR follows holdoff
      tbl[11] = mk(1, 1, 0, 0, 1, 1, 0, 1, 8'h02);
      tbl[12] = mk(1, 1, 0, 0, 1, 1, 0, 1, 8'h02);
      tbl[13] = mk(1, 1, 1, 0, 0, 1, 0, 0, 8'h00);
      tbl[14] = mk(1, 1, 0, 0, 0, 1, 0, 0, 8'h00);
      tbl[15] = mk(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
      for (int i = 16; i < 21; i++) tbl[i] = mk(1, 1, 0, 1, 0, 1, 0, 0, 8'h00);
      // INTR withdrawn by the final ack clock -> spurious, no vector
      tbl[21] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);
      tbl[22] = mk(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
      tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h00);

      // Reset state, asserted before any clock edge
      reset = 1'b1;
      set_in(0, 8'h00, 0, 0, 0, 0);
      m_reset();
      #3;
      check("rst_pic_ack", {7'd0, pic_ack}, 8'd0);
      check("rst_valid", {7'd0, vector_valid}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_spur", {7'd0, spurious}, 8'd0);
      check("rst_vec", vector_out, 8'h00);
      do_reset();

      foreach (tbl[i]) begin
         set_in(tbl[i].intr, tbl[i].vec, tbl[i].nmi_i, tbl[i].ifl, tbl[i].ib, tbl[i].taken);
         tick();
         check($sformatf("tbl%0d_ack", i), {7'd0, pic_ack}, {7'd0, tbl[i].e_ack});
         check($sformatf("tbl%0d_valid", i), {7'd0, vector_valid}, {7'd0, tbl[i].e_val});
         check($sformatf("tbl%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].e_busy});
         check($sformatf("tbl%0d_spur", i), {7'd0, spurious}, {7'd0, tbl[i].e_spur});
         if (tbl[i].e_val) begin
            check($sformatf("tbl%0d_vec", i), vector_out, tbl[i].e_vec);
            check($sformatf("tbl%0d_isnmi", i), {7'd0, vector_is_nmi}, {7'd0, tbl[i].e_nmi});
         end
      end

      // INTR masked by IF for 50 clocks, then enabled
      do_reset();
      set_in(1, 8'h21, 0, 0, 1, 0);
      for (int i = 0; i < 50; i++) begin
         tick();
         check("masked_ack", {7'd0, pic_ack}, 8'd0);
         check("masked_busy", {7'd0, busy}, 8'd0);
      end
      cpu_if = 1'b1;
      tick();
      check("unmask_ack", {7'd0, pic_ack}, 8'd1);
      cpu_if = 1'b0;
      nmi = 1'b1;               // becomes pending during the ack
      tick();
      tick();
      check("ack3_ack", {7'd0, pic_ack}, 8'd1);

      // Asynchronous reset in the middle of ack clock 3
      #2;
      reset = 1'b1;
      nmi = 1'b0;
      m_reset();
      #1;
      check("async_pic_ack", {7'd0, pic_ack}, 8'd0);
      check("async_busy", {7'd0, busy}, 8'd0);
      check("async_valid", {7'd0, vector_valid}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 8'h00, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_no_nmi", {7'd0, vector_valid}, 8'd0);
         check("post_rst_busy", {7'd0, busy}, 8'd0);
      end

      // Clean sequence after release; vector must hold while CPU stalls
      set_in(1, 8'h33, 0, 1, 1, 0);
      for (int i = 0; i < ACK; i++) begin
         tick();
         check("clean_ack", {7'd0, pic_ack}, 8'd1);
         intr_in = 1'b1;
      end
      tick();
      check("clean_valid", {7'd0, vector_valid}, 8'd1);
      check("clean_vec", vector_out, 8'h33);
      for (int i = 0; i < 20; i++) begin
         pic_vector = 8'($urandom);
         cpu_if = 1'($urandom);
         inst_boundary = 1'($urandom);
         tick();
         check("stall_valid", {7'd0, vector_valid}, 8'd1);
         check("stall_vec", vector_out, 8'h33);
         check("stall_isnmi", {7'd0, vector_is_nmi}, 8'd0);
      end
      intr_in = 1'b0;
      vector_taken = 1'b1;
      tick();
      check("take_valid", {7'd0, vector_valid}, 8'd0);
      check("take_busy", {7'd0, busy}, 8'd1);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         intr_in       = ($urandom_range(0, 3) != 0);
         pic_vector    = 8'($urandom);
         if ($urandom_range(0, 19) == 0) nmi = ~nmi;
         cpu_if        = ($urandom_range(0, 3) != 0);
         inst_boundary = 1'($urandom);
         vector_taken  = ($urandom_range(0, 9) < 3);
         tick();
         check_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
